parity_serial_checker: RTL and testbench
========================================

// Module: parity_serial_checker
// PURPOSE
//  Receive end of the lab's odd-parity link: takes a serial stream of DATA_W data bits plus one
//  parity bit per frame. The transmitter sets the parity bit to 1 when the data has an even number
//  of ones. This block deserialises each frame and checks parity (total ones must be odd).
//  Each frame is presented on a one-entry valid/ready output register with an error flag.
//  Sits between the serial link model and the downstream consumer/display logic.
// PARAMETERS
//  DATA_W     3  data bits per frame, >=1 (3 pairs with the 3-bit generator)
//  ERR_CNT_W  8  width of saturating parity-error counter
// PORTS
//  clk          in   1          rising-edge clock, single domain
//  rst_n        in   1          asynchronous, active-low reset
//  bit_valid    in   1          bit_in is sampled this cycle
//  bit_in       in   1          serial bit (MSB first, parity bit last)
//  frame_start  in   1          qualifies bit_in as first data bit of a new frame (only with bit_valid)
//  out_ready    in   1          consumer accepts out_data this cycle
//  out_valid    out  1          out_data/out_perr hold a frame
//  out_data     out  DATA_W     deserialised data, first received bit = out_data[DATA_W-1]
//  out_perr     out  1          1 = frame failed odd-parity check
//  overrun      out  1          1-cycle pulse: completed frame dropped, output register still full
//  frame_abort  out  1          1-cycle pulse: frame_start arrived mid-frame, partial frame discarded
//  err_cnt      out  ERR_CNT_W  parity errors seen, saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, bit counter=0, shift reg=0, running parity=0.
//   All outputs are 0. Deassertion takes effect on the next clock edge; mid-frame reset discards the frame.
//  Cycles without bit_valid hold all state; bits may arrive with arbitrary gaps.
//  FSM: IDLE / DATA / PARITY.
//   IDLE:   bit_valid&frame_start -> shreg<={..,bit_in}, par<=bit_in, cnt<=1.
//           Next state: PARITY if DATA_W==1, else DATA. bit_valid without frame_start is ignored.
//   DATA:   bit_valid&!frame_start -> shift, par^=bit_in, cnt++. Go to PARITY when cnt reaches DATA_W.
//   PARITY: bit_valid&!frame_start -> perr = ~(par^bit_in). Complete frame, go to IDLE.
//   DATA/PARITY with bit_valid&frame_start -> frame_abort pulse; restart as from IDLE with this bit.
//  Completion (the cycle the parity bit is sampled), with full = out_valid & ~out_ready:
//   !full -> next cycle: out_valid=1, out_data=shreg, out_perr=perr. Latency is one clock after the parity bit.
//   full  -> frame dropped, overrun pulses next cycle, output register unchanged.
//   Handshake at completion: out_valid&out_ready in the same cycle counts as not full.
//   The new frame loads with no bubble and no overrun.
//  Output register: out_valid falls the cycle after out_valid&out_ready, unless it is reloaded.
//   out_data/out_perr are stable while out_valid=1 and out_ready=0.
//  err_cnt: +1 on every completed frame with perr=1, including dropped frames. Holds at 2^ERR_CNT_W-1.
//   Aborted frames never count.
// STRUCTURE
//  parity_pkg: FSM state enum (ST_IDLE/ST_DATA/ST_PARITY); localparam ODD_PARITY=1'b1;
//   function for the counter width, $clog2(DATA_W+1).
//  One sub-module, parity_rx_shreg: shift register + running XOR + bit counter.
//   It has load/shift/clear controls. The FSM, output register and error counter stay in the top.
// TESTING
//  DATA_W=3: send 1,0,1 then parity 1 (3 ones total... 101 has 2 ones, parity 1).
//   -> out_valid=1 one cycle later, out_data=3'b101, out_perr=0.
//  Send 1,1,0 then parity 0 -> out_data=3'b110, out_perr=1, err_cnt 0->1.
//  Hold out_ready=0, send two good frames -> first frame held intact. Second completion -> overrun pulse, err_cnt unchanged.
//  out_ready=1 on the same cycle the next parity bit arrives -> next data loads, out_valid stays 1, no overrun.
//  frame_start after 2 data bits, then 0,0,0 + parity 1 -> frame_abort pulse, out_data=3'b000, out_perr=0.
//  Drive rst_n=0 mid-frame, then send a full frame; 256 error frames with ERR_CNT_W=8.
//   -> After reset, outputs are 0 and the next frame decodes correctly. err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the odd-parity serial receiver.
package parity_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Data ones plus the parity bit must add up to an odd count.
    localparam logic ODD_PARITY = 1'b1;

    // The bit counter must be able to hold the value DATA_W.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/parity_rx_shreg.sv
// Deserialiser datapath: shift register, running XOR of data bits and a received-bit counter.
// Priority of controls: clear > load > shift. Load starts a new frame with bit_in as its first bit.
module parity_rx_shreg
    import parity_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int CNT_W  = cnt_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              shift,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data,
    output logic              par,
    output logic [CNT_W-1:0]  cnt
);

    logic [DATA_W-1:0] shreg_shift;

    // A one-bit frame has nothing to keep from the previous contents.
    if (DATA_W == 1) begin : g_one
        assign shreg_shift = bit_in;
    end else begin : g_multi
        assign shreg_shift = {data[DATA_W-2:0], bit_in};
    end

    // Shift register, running parity and bit count update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            par  <= 1'b0;
            cnt  <= '0;
        end else if (clear) begin
            data <= '0;
            par  <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            data <= shreg_shift;
            par  <= bit_in;
            cnt  <= CNT_W'(1);
        end else if (shift) begin
            data <= shreg_shift;
            par  <= par ^ bit_in;
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_serial_checker.sv
// Receive end of the odd-parity serial link: deserialises DATA_W data bits plus one parity bit,
// checks parity and presents each frame on a one-entry valid/ready output register.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a bit qualified by frame_start
//   ST_DATA   | collecting data bits 2..DATA_W
//   ST_PARITY | all data bits held, next bit is the parity bit
module parity_serial_checker
    import parity_pkg::*;
#(
    parameter int DATA_W    = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 frame_start,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_perr,
    output logic                 overrun,
    output logic                 frame_abort,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam state_t          ST_FIRST = (DATA_W == 1) ? ST_PARITY : ST_DATA;

    state_t            state;
    state_t            state_nxt;

    logic              sr_clear;
    logic              sr_load;
    logic              sr_shift;
    logic [DATA_W-1:0] sr_data;
    logic              sr_par;
    logic [CNT_W-1:0]  sr_cnt;

    logic              complete;
    logic              abort;
    logic              perr;
    logic              full;

    parity_rx_shreg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (sr_clear),
        .load   (sr_load),
        .shift  (sr_shift),
        .bit_in (bit_in),
        .data   (sr_data),
        .par    (sr_par),
        .cnt    (sr_cnt)
    );

    // A consumer taking the held frame this cycle frees the slot for a completing frame.
    assign full = out_valid & ~out_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control; cycles without bit_valid hold everything.
    always_comb begin
        state_nxt = state;
        sr_clear  = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        perr      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bit_valid && frame_start) begin
                    sr_load   = 1'b1;
                    state_nxt = ST_FIRST;
                end
            end
            ST_DATA: begin
                if (bit_valid && frame_start) begin
                    abort     = 1'b1;
                    sr_load   = 1'b1;
                    state_nxt = ST_FIRST;
                end else if (bit_valid) begin
                    sr_shift = 1'b1;
                    if (sr_cnt == LAST_CNT) begin
                        state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_valid && frame_start) begin
                    abort     = 1'b1;
                    sr_load   = 1'b1;
                    state_nxt = ST_FIRST;
                end else if (bit_valid) begin
                    complete  = 1'b1;
                    perr      = ((sr_par ^ bit_in) != ODD_PARITY);
                    sr_clear  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-entry output register: load on completion when free, drop valid after a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_perr  <= 1'b0;
        end else if (complete && !full) begin
            out_valid <= 1'b1;
            out_data  <= sr_data;
            out_perr  <= perr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Status pulses, one cycle after the event that caused them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            overrun     <= complete & full;
            frame_abort <= abort;
        end
    end

    // Saturating parity-error counter; dropped frames still count, aborted ones never complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (complete && perr && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_serial_checker.sv
// Directed bench for parity_serial_checker with DATA_W=3, ERR_CNT_W=8.
module tb_parity_serial_checker;

    logic       clk;
    logic       rst_n;
    logic       bit_valid;
    logic       bit_in;
    logic       frame_start;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_perr;
    logic       overrun;
    logic       frame_abort;
    logic [7:0] err_cnt;

    int n_checks;
    int n_errors;

    parity_serial_checker #(
        .DATA_W    (3),
        .ERR_CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .frame_start (frame_start),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_perr    (out_perr),
        .overrun     (overrun),
        .frame_abort (frame_abort),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one bit for one clock; returns 1 time unit after the sampling edge.
    task automatic send_bit(input logic b, input logic fs);
        bit_valid   = 1'b1;
        bit_in      = b;
        frame_start = fs;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_data(input logic [2:0] d);
        send_bit(d[2], 1'b1);
        send_bit(d[1], 1'b0);
        send_bit(d[0], 1'b0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_data"}, 32'(out_data), 32'd0);
        check_eq({tag, "_perr"}, 32'(out_perr), 32'd0);
        check_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
        check_eq({tag, "_abort"}, 32'(frame_abort), 32'd0);
        check_eq({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;

        #3;
        check_reset_outputs("rst0");
        #9;
        rst_n = 1'b1;
        idle_cycle();

        // Good frame 101 + parity 1, with a gap between data bits.
        send_bit(1'b1, 1'b1);
        idle_cycle();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check_eq("t1_pre_valid", 32'(out_valid), 32'd0);
        send_bit(1'b1, 1'b0);
        check_eq("t1_valid", 32'(out_valid), 32'd1);
        check_eq("t1_data", 32'(out_data), 32'b101);
        check_eq("t1_perr", 32'(out_perr), 32'd0);
        check_eq("t1_errcnt", 32'(err_cnt), 32'd0);
        out_ready = 1'b1;
        idle_cycle();
        out_ready = 1'b0;
        check_eq("t1_drain", 32'(out_valid), 32'd0);

        // Bad frame 110 + parity 0.
        send_data(3'b110);
        send_bit(1'b0, 1'b0);
        check_eq("t2_valid", 32'(out_valid), 32'd1);
        check_eq("t2_data", 32'(out_data), 32'b110);
        check_eq("t2_perr", 32'(out_perr), 32'd1);
        check_eq("t2_errcnt", 32'(err_cnt), 32'd1);
        out_ready = 1'b1;
        idle_cycle();
        out_ready = 1'b0;

        // Two good frames with the consumer stalled: second one overruns.
        send_data(3'b011);
        send_bit(1'b1, 1'b0);
        check_eq("t3_data1", 32'(out_data), 32'b011);
        send_data(3'b100);
        check_eq("t3_hold_mid", 32'(out_data), 32'b011);
        send_bit(1'b0, 1'b0);
        check_eq("t3_ovr", 32'(overrun), 32'd1);
        check_eq("t3_hold_data", 32'(out_data), 32'b011);
        check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
        check_eq("t3_errcnt", 32'(err_cnt), 32'd1);
        idle_cycle();
        check_eq("t3_ovr_pulse", 32'(overrun), 32'd0);

        // Handshake in the completion cycle: no bubble, no overrun.
        send_data(3'b111);
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        out_ready = 1'b0;
        check_eq("t4_valid", 32'(out_valid), 32'd1);
        check_eq("t4_data", 32'(out_data), 32'b111);
        check_eq("t4_perr", 32'(out_perr), 32'd0);
        check_eq("t4_ovr", 32'(overrun), 32'd0);

        // Dropped error frame still counts.
        send_data(3'b000);
        send_bit(1'b0, 1'b0);
        check_eq("t4b_ovr", 32'(overrun), 32'd1);
        check_eq("t4b_data", 32'(out_data), 32'b111);
        check_eq("t4b_errcnt", 32'(err_cnt), 32'd2);
        out_ready = 1'b1;
        idle_cycle();
        out_ready = 1'b0;
        check_eq("t4b_drain", 32'(out_valid), 32'd0);

        // Restart after two data bits.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        check_eq("t5_abort", 32'(frame_abort), 32'd1);
        send_bit(1'b0, 1'b0);
        check_eq("t5_abort_pulse", 32'(frame_abort), 32'd0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check_eq("t5_valid", 32'(out_valid), 32'd1);
        check_eq("t5_data", 32'(out_data), 32'b000);
        check_eq("t5_perr", 32'(out_perr), 32'd0);
        check_eq("t5_errcnt", 32'(err_cnt), 32'd2);
        check_eq("t5_ovr", 32'(overrun), 32'd0);

        // Reset in the middle of a frame while a frame is held.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        #3;
        check_reset_outputs("rst1");
        #3;
        rst_n = 1'b1;
        idle_cycle();
        send_bit(1'b1, 1'b0);
        check_eq("t6_ignored", 32'(out_valid), 32'd0);
        send_data(3'b010);
        send_bit(1'b0, 1'b0);
        check_eq("t6_valid", 32'(out_valid), 32'd1);
        check_eq("t6_data", 32'(out_data), 32'b010);
        check_eq("t6_perr", 32'(out_perr), 32'd0);
        check_eq("t6_errcnt", 32'(err_cnt), 32'd0);

        // Error counter saturation.
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            send_data(3'b000);
            send_bit(1'b0, 1'b0);
        end
        check_eq("t7_errcnt255", 32'(err_cnt), 32'hFF);
        check_eq("t7_perr", 32'(out_perr), 32'd1);
        send_data(3'b000);
        send_bit(1'b0, 1'b0);
        check_eq("t7_sat", 32'(err_cnt), 32'hFF);
        check_eq("t7_ovr", 32'(overrun), 32'd0);
        idle_cycle();
        check_eq("t7_drain", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
